interrupt_sequencer: RTL and testbench

//  Priority resolver and INTA sequencer for the 8259A PIC. Takes latched IRR requests
//  and the IMR mask, picks the winning IR under fully nested priority (fixed or

---
 rtl/interrupt_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer
//  Description : 8259A priority resolver and INTA sequencer. Resolves the
//                winning IR under fully nested (fixed or rotating) priority,
//                raises INT, runs the two-pulse INTA handshake, owns the ISR,
//                pulses IRR-clear, drives the 8086-mode vector and executes
//                EOI commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
   parameter int VEC_HI_W     = 5,
   parameter int INTA_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          irrReq,
   input  logic [7:0]          IMR_reg,
   input  logic [VEC_HI_W-1:0] vectorBase,
   input  logic                autoEOI,
   input  logic                eoiCmd,
   input  logic                eoiSpecific,
   input  logic [2:0]          eoiLevel,
   input  logic                rotate,
   input  logic                INTA,
   output logic                INT,
   output logic [7:0]          clearIRR,
   output logic [7:0]          ISR_reg,
   output logic [7:0]          dataBuffer
);

   localparam int                c_TMR_W    = (INTA_TIMEOUT < 2) ? 1 : $clog2(INTA_TIMEOUT);
   localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(INTA_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PEND  = 2'd1,
      S_WAIT2 = 2'd2,
      S_DRIVE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_n;
   logic                 r_int;
   logic                 w_int_n;
   logic [7:0]           r_isr;
   logic [7:0]           w_isr_n;
   logic [7:0]           r_clr;
   logic [7:0]           w_clr_n;
   logic [2:0]           r_lowpri;
   logic [2:0]           w_lowpri_n;
   logic [2:0]           r_winner;
   logic [2:0]           w_winner_n;
   logic                 r_spurious;
   logic                 w_spurious_n;
   logic [c_TMR_W-1:0]   r_tmr;
   logic [c_TMR_W-1:0]   w_tmr_n;
   logic                 r_inta_q;

   logic [7:0]           w_cand;
   logic [3:0]           w_cand_top;
   logic [3:0]           w_isr_top;
   logic                 w_eligible;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_eoi_hit;
   logic [2:0]           w_eoi_lvl;
   logic [7:0]           w_eoi_mask;
   logic [7:0]           w_set_mask;
   logic                 w_auto_hit;
   logic [7:0]           w_auto_mask;
   logic [VEC_HI_W+2:0]  w_vector;

   // Highest-priority set bit: {found, level}. Priority runs from lowpri+1
   // downward cyclically, so the scan goes lowest first and the last hit wins.
   function automatic logic [3:0] f_top(input logic [7:0] bits, input logic [2:0] lowpri);
      logic [3:0] res;
      logic [2:0] lvl;
      res = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         lvl = lowpri + 3'd1 + k[2:0];
         if (bits[lvl]) res = {1'b1, lvl};
      end
      return res;
   endfunction

   // Rank 0 is the highest priority level under the current rotation.
   function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lowpri);
      return lvl - lowpri - 3'd1;
   endfunction

   assign w_cand     = irrReq & ~IMR_reg;
   assign w_cand_top = f_top(w_cand, r_lowpri);
   assign w_isr_top  = f_top(r_isr, r_lowpri);
   assign w_eligible = w_cand_top[3] &&
                       (!w_isr_top[3] ||
                        (f_rank(w_cand_top[2:0], r_lowpri) < f_rank(w_isr_top[2:0], r_lowpri)));
   assign w_rise     = INTA & ~r_inta_q;
   assign w_fall     = ~INTA & r_inta_q;

   assign w_vector   = {vectorBase, r_winner};
   assign dataBuffer = ((r_state == S_DRIVE) && INTA) ? w_vector[7:0] : 8'bz;
   assign INT        = r_int;
   assign clearIRR   = r_clr;
   assign ISR_reg    = r_isr;

   // EOI decode against the ISR as it stands before this cycle's update
   always_comb begin
      w_eoi_hit = 1'b0;
      w_eoi_lvl = 3'd0;
      if (eoiCmd) begin
         if (eoiSpecific) begin
            w_eoi_hit = r_isr[eoiLevel];
            w_eoi_lvl = eoiLevel;
         end else begin
            w_eoi_hit = w_isr_top[3];
            w_eoi_lvl = w_isr_top[2:0];
         end
      end
      w_eoi_mask = w_eoi_hit ? (8'd1 << w_eoi_lvl) : 8'd0;
   end

   // Handshake FSM next-state plus ISR / priority bookkeeping
   always_comb begin
      w_state_n    = r_state;
      w_int_n      = r_int;
      w_clr_n      = 8'd0;
      w_set_mask   = 8'd0;
      w_winner_n   = r_winner;
      w_spurious_n = r_spurious;
      w_tmr_n      = r_tmr;
      w_auto_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_eligible) begin
               w_state_n = S_PEND;
               w_int_n   = 1'b1;
            end
         end
         S_PEND: begin
            if (w_rise) begin
               // Winner is frozen here; losing eligibility on this edge is spurious
               if (w_eligible) begin
                  w_winner_n   = w_cand_top[2:0];
                  w_spurious_n = 1'b0;
                  w_set_mask   = 8'd1 << w_cand_top[2:0];
                  w_clr_n      = 8'd1 << w_cand_top[2:0];
               end else begin
                  w_winner_n   = 3'd7;
                  w_spurious_n = 1'b1;
               end
               w_int_n   = 1'b0;
               w_tmr_n   = '0;
               w_state_n = S_WAIT2;
            end else if (!w_eligible) begin
               w_int_n   = 1'b0;
               w_state_n = S_IDLE;
            end
         end
         S_WAIT2: begin
            if (w_rise) begin
               w_state_n = S_DRIVE;
            end else if (r_tmr == c_TMR_LAST) begin
               w_state_n = S_IDLE;
            end else begin
               w_tmr_n = r_tmr + 1'b1;
            end
         end
         S_DRIVE: begin
            if (w_fall) begin
               w_auto_hit = autoEOI && !r_spurious;
               w_state_n  = S_IDLE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase

      w_auto_mask = w_auto_hit ? (8'd1 << r_winner) : 8'd0;
      w_isr_n     = (r_isr & ~w_eoi_mask & ~w_auto_mask) | w_set_mask;

      w_lowpri_n = r_lowpri;
      if (rotate && w_eoi_hit)
         w_lowpri_n = w_eoi_lvl;
      else if (rotate && w_auto_hit)
         w_lowpri_n = r_winner;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_n;
   end

   // Datapath registers: INT, ISR, IRR-clear pulse, rotation and handshake context
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_int      <= 1'b0;
         r_isr      <= 8'd0;
         r_clr      <= 8'd0;
         r_lowpri   <= 3'd7;
         r_winner   <= 3'd7;
         r_spurious <= 1'b0;
         r_tmr      <= '0;
         r_inta_q   <= 1'b0;
      end else begin
         r_int      <= w_int_n;
         r_isr      <= w_isr_n;
         r_clr      <= w_clr_n;
         r_lowpri   <= w_lowpri_n;
         r_winner   <= w_winner_n;
         r_spurious <= w_spurious_n;
         r_tmr      <= w_tmr_n;
         r_inta_q   <= INTA;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_sequencer
//  Description : Self-checking bench for interrupt_sequencer: a table of
//                per-cycle vectors followed by hand-written multi-cycle
//                sequences (auto-EOI, INTA timeout, async reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

   logic       clk;
   logic       reset;
   logic [7:0] irrReq;
   logic [7:0] IMR_reg;
   logic [4:0] vectorBase;
   logic       autoEOI;
   logic       eoiCmd;
   logic       eoiSpecific;
   logic [2:0] eoiLevel;
   logic       rotate;
   logic       INTA;
   logic       INT;
   logic [7:0] clearIRR;
   logic [7:0] ISR_reg;
   wire  [7:0] dbus;

   int checks = 0;
   int fails  = 0;

   interrupt_sequencer #(.VEC_HI_W(5), .INTA_TIMEOUT(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .irrReq      (irrReq),
      .IMR_reg     (IMR_reg),
      .vectorBase  (vectorBase),
      .autoEOI     (autoEOI),
      .eoiCmd      (eoiCmd),
      .eoiSpecific (eoiSpecific),
      .eoiLevel    (eoiLevel),
      .rotate      (rotate),
      .INTA        (INTA),
      .INT         (INT),
      .clearIRR    (clearIRR),
      .ISR_reg     (ISR_reg),
      .dataBuffer  (dbus)
   );

   // 10 time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] irr;
      logic [7:0] imr;
      logic       inta;
      logic       eoi;
      logic       spec;
      logic [2:0] lvl;
      logic       rot;
      logic       e_int;
      logic [7:0] e_isr;
      logic [7:0] e_clr;
      logic       e_drv;
      logic [7:0] e_bus;
   } vec_t;

   vec_t tbl[42];

   function automatic vec_t mk(input logic [7:0] irr, input logic [7:0] imr, input logic inta,
                               input logic eoi, input logic spec, input logic [2:0] lvl,
                               input logic rot, input logic e_int, input logic [7:0] e_isr,
                               input logic [7:0] e_clr, input logic e_drv, input logic [7:0] e_bus);
      vec_t v;
      v.irr = irr; v.imr = imr; v.inta = inta; v.eoi = eoi; v.spec = spec; v.lvl = lvl;
      v.rot = rot; v.e_int = e_int; v.e_isr = e_isr; v.e_clr = e_clr; v.e_drv = e_drv;
      v.e_bus = e_bus;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // A released bus reads as z (4-state) or 0 (2-state); vectors used here are never 0
   task automatic chk_bus(input string name, input logic drv, input logic [7:0] exp);
      logic ok;
      checks++;
      if (drv) ok = (dbus === exp);
      else     ok = (dbus === 8'hzz) || (dbus === 8'h00);
      if (!ok) begin
         fails++;
         if (drv) $display("FAIL %s: bus %h expected %h", name, dbus, exp);
         else     $display("FAIL %s: bus %h expected released", name, dbus);
      end
   endtask

   task automatic clear_inputs();
      irrReq = 8'h00; IMR_reg = 8'h00; autoEOI = 1'b0; eoiCmd = 1'b0;
      eoiSpecific = 1'b0; eoiLevel = 3'd0; rotate = 1'b0; INTA = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      vectorBase = 5'h08;
      clear_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("reset INT", {7'd0, INT}, 8'h00);
      chk("reset ISR", ISR_reg, 8'h00);
      chk("reset clearIRR", clearIRR, 8'h00);
      chk_bus("reset bus", 1'b0, 8'h00);

      //           irr    imr   ia  eoi sp lvl rot  INT  ISR    clr   drv bus
      tbl[0]  = mk(8'h24, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
      tbl[1]  = mk(8'h24, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h04, 8'h04, 0, 8'h00);
      tbl[2]  = mk(8'h20, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h04, 8'h00, 0, 8'h00);
      tbl[3]  = mk(8'h20, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h04, 8'h00, 0, 8'h00);
      tbl[4]  = mk(8'h20, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h04, 8'h00, 1, 8'h42);
      tbl[5]  = mk(8'h20, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h04, 8'h00, 1, 8'h42);
      tbl[6]  = mk(8'h20, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h04, 8'h00, 0, 8'h00);
      tbl[7]  = mk(8'h20, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h04, 8'h00, 0, 8'h00);
      tbl[8]  = mk(8'h02, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h04, 8'h00, 0, 8'h00);
      tbl[9]  = mk(8'h02, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h06, 8'h02, 0, 8'h00);
      tbl[10] = mk(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h06, 8'h00, 0, 8'h00);
      tbl[11] = mk(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h06, 8'h00, 1, 8'h41);
      tbl[12] = mk(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h06, 8'h00, 0, 8'h00);
      tbl[13] = mk(8'h00, 8'h00, 0, 1, 0, 3'd0, 0, 0, 8'h04, 8'h00, 0, 8'h00);
      tbl[14] = mk(8'h00, 8'h00, 0, 1, 0, 3'd0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[15] = mk(8'h09, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
      tbl[16] = mk(8'h09, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h08, 8'h08, 0, 8'h00);
      tbl[17] = mk(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h08, 8'h00, 0, 8'h00);
      tbl[18] = mk(8'h01, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h08, 8'h00, 1, 8'h43);
      tbl[19] = mk(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h08, 8'h00, 0, 8'h00);
      tbl[20] = mk(8'h01, 8'h00, 0, 1, 1, 3'd3, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[21] = mk(8'h01, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
      tbl[22] = mk(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[23] = mk(8'h00, 8'h00, 0, 1, 1, 3'd5, 1, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[24] = mk(8'hFF, 8'hFF, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[25] = mk(8'hFF, 8'hFF, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[26] = mk(8'h08, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
      tbl[27] = mk(8'h08, 8'h08, 1, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[28] = mk(8'h08, 8'h08, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[29] = mk(8'h08, 8'h08, 1, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 1, 8'h47);
      tbl[30] = mk(8'h08, 8'h08, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[31] = mk(8'h08, 8'h08, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      tbl[32] = mk(8'h50, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
      tbl[33] = mk(8'h50, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h10, 8'h10, 0, 8'h00);
      tbl[34] = mk(8'h40, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h10, 8'h00, 0, 8'h00);
      tbl[35] = mk(8'h40, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h10, 8'h00, 1, 8'h44);
      tbl[36] = mk(8'h40, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h10, 8'h00, 0, 8'h00);
      tbl[37] = mk(8'h48, 8'h00, 0, 0, 0, 3'd0, 0, 1, 8'h10, 8'h00, 0, 8'h00);
      tbl[38] = mk(8'h48, 8'h00, 1, 1, 0, 3'd0, 0, 0, 8'h08, 8'h08, 0, 8'h00);
      tbl[39] = mk(8'h40, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h08, 8'h00, 0, 8'h00);
      tbl[40] = mk(8'h40, 8'h00, 1, 0, 0, 3'd0, 0, 0, 8'h08, 8'h00, 1, 8'h43);
      tbl[41] = mk(8'h40, 8'h00, 0, 0, 0, 3'd0, 0, 0, 8'h08, 8'h00, 0, 8'h00);

      // INT must not be up in the same cycle the first request appears
      irrReq = tbl[0].irr;
      #1;
      chk("req same-cycle INT", {7'd0, INT}, 8'h00);

      for (int i = 0; i < 42; i++) begin
         irrReq      = tbl[i].irr;
         IMR_reg     = tbl[i].imr;
         INTA        = tbl[i].inta;
         eoiCmd      = tbl[i].eoi;
         eoiSpecific = tbl[i].spec;
         eoiLevel    = tbl[i].lvl;
         rotate      = tbl[i].rot;
         step();
         chk($sformatf("row%0d INT", i), {7'd0, INT}, {7'd0, tbl[i].e_int});
         chk($sformatf("row%0d ISR", i), ISR_reg, tbl[i].e_isr);
         chk($sformatf("row%0d clearIRR", i), clearIRR, tbl[i].e_clr);
         chk_bus($sformatf("row%0d bus", i), tbl[i].e_drv, tbl[i].e_bus);
      end

      // Auto-EOI, second INTA arriving on the last cycle before the timeout
      do_reset();
      autoEOI = 1'b1;
      irrReq = 8'h01;
      step();
      chk("aeoi INT", {7'd0, INT}, 8'h01);
      INTA = 1'b1;
      step();
      chk("aeoi ISR set", ISR_reg, 8'h01);
      chk("aeoi clearIRR", clearIRR, 8'h01);
      irrReq = 8'h00;
      INTA = 1'b0;
      repeat (14) step();
      chk("aeoi wait INT", {7'd0, INT}, 8'h00);
      INTA = 1'b1;
      step();
      chk_bus("aeoi vector", 1'b1, 8'h40);
      chk("aeoi ISR held", ISR_reg, 8'h01);
      INTA = 1'b0;
      step();
      chk("aeoi ISR cleared", ISR_reg, 8'h00);
      chk_bus("aeoi bus after fall", 1'b0, 8'h00);

      // Second INTA withheld for the full timeout: back to idle, ISR kept
      irrReq = 8'h01;
      step();
      chk("tmo INT", {7'd0, INT}, 8'h01);
      INTA = 1'b1;
      step();
      chk("tmo ISR set", ISR_reg, 8'h01);
      irrReq = 8'h00;
      INTA = 1'b0;
      repeat (15) step();
      INTA = 1'b1;
      step();
      chk_bus("tmo late INTA bus", 1'b0, 8'h00);
      chk("tmo ISR kept", ISR_reg, 8'h01);
      chk("tmo INT", {7'd0, INT}, 8'h00);
      INTA = 1'b0;
      step();

      // Asynchronous reset in WAIT2 clears outputs between clock edges
      do_reset();
      irrReq = 8'h10;
      step();
      chk("rst-w2 INT", {7'd0, INT}, 8'h01);
      INTA = 1'b1;
      step();
      chk("rst-w2 ISR set", ISR_reg, 8'h10);
      #2 reset = 1'b1;
      #1;
      chk("rst-w2 INT", {7'd0, INT}, 8'h00);
      chk("rst-w2 ISR", ISR_reg, 8'h00);
      chk("rst-w2 clearIRR", clearIRR, 8'h00);
      chk_bus("rst-w2 bus", 1'b0, 8'h00);
      irrReq = 8'h00;
      INTA = 1'b0;
      step();
      reset = 1'b0;

      // Asynchronous reset while the vector is on the bus releases it at once
      irrReq = 8'h02;
      step();
      INTA = 1'b1;
      step();
      irrReq = 8'h00;
      INTA = 1'b0;
      step();
      INTA = 1'b1;
      step();
      chk_bus("rst-drv vector", 1'b1, 8'h41);
      #2 reset = 1'b1;
      #1;
      chk_bus("rst-drv bus", 1'b0, 8'h00);
      chk("rst-drv ISR", ISR_reg, 8'h00);
      INTA = 1'b0;
      step();
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
